// File: rtl/mem_lsu.sv
`default_nettype none
// =============================================================================
// mem_lsu : byte-serial RV32I load/store unit in front of a byte-wide RAM.
// Optional macro MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
// Revision: 1.0
// =============================================================================
module mem_lsu #(
  parameter int ADDR_W = 17,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              ld_i,
  input  logic              st_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       sdata_i,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  input  logic              ram_ack_i,
  output logic [RA_W-1:0]   wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_k;
  logic [31:0] r_asm;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_legal_size;
  logic        w_req;
  logic        w_misalign;
  logic        w_go;
  logic [1:0]  w_last_k;
  logic        w_last;
  logic [31:0] w_ext;

  assign w_is_byte    = (funct3_i[1:0] == 2'b00);
  assign w_is_half    = (funct3_i[1:0] == 2'b01);
  assign w_is_word    = (funct3_i == 3'b010);
  assign w_legal_size = w_is_byte | w_is_half | w_is_word;
  assign w_req        = ld_i ^ st_i;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_req & ((w_is_half & addr_i[0]) |
                               (w_is_word & (addr_i[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_go     = w_req & w_legal_size & ~w_misalign;
  assign w_last_k = w_is_byte ? 2'd0 : (w_is_half ? 2'd1 : 2'd3);
  assign w_last   = (r_k == w_last_k);

  // Unsigned variants (LBU/LHU) have funct3[2] set and suppress the sign fill.
  always_comb begin
    w_ext = r_asm;
    if (w_is_byte) begin
      w_ext = {{24{~funct3_i[2] & r_asm[7]}}, r_asm[7:0]};
    end else if (w_is_half) begin
      w_ext = {{16{~funct3_i[2] & r_asm[15]}}, r_asm[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= 2'd0;
      r_asm <= 32'd0;
    end else if ((r_state == S_IDLE) && w_go) begin
      r_k   <= 2'd0;
      r_asm <= 32'd0;
    end else if ((r_state == S_XFER) && ram_ack_i) begin
      if (ld_i) begin
        r_asm[{r_k, 3'b000} +: 8] <= ram_rdata_i;
      end
      r_k <= w_last ? 2'd0 : (r_k + 2'd1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = 8'd0;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (ld_i | st_i) begin
          wreg_o = 1'b0;
          if (w_go) begin
            stall_o     = 1'b1;
            w_state_nxt = S_XFER;
          end else begin
            misalign_o = w_misalign;
          end
        end
      end
      S_XFER: begin
        stall_o     = 1'b1;
        wreg_o      = 1'b0;
        ram_req_o   = 1'b1;
        ram_we_o    = st_i;
        ram_addr_o  = addr_i + {{(ADDR_W-2){1'b0}}, r_k};
        ram_wdata_o = st_i ? sdata_i[{r_k, 3'b000} +: 8] : 8'd0;
        if (ram_ack_i && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (ld_i) begin
          wreg_o  = wreg_i;
          wdata_o = w_ext;
        end else begin
          wreg_o  = 1'b0;
          wdata_o = 32'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Reset overrides everything so an in-flight store is abandoned cleanly.
    if (rst) begin
      w_state_nxt = S_IDLE;
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = 8'd0;
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      stall_o     = 1'b0;
      misalign_o  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// =============================================================================
// tb_mem_lsu : directed self-checking bench for mem_lsu with a byte RAM model.
// Revision: 1.0
// =============================================================================
module tb_mem_lsu;

  localparam int ADDR_W = 17;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [RA_W-1:0]   wd_i;
  logic              wreg_i;
  logic [31:0]       wdata_i;
  logic              ld_i;
  logic              st_i;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       sdata_i;
  logic              ram_req_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i = 8'd0;
  logic              ram_ack_i = 1'b0;
  logic [RA_W-1:0]   wd_o;
  logic              wreg_o;
  logic [31:0]       wdata_o;
  logic              stall_o;
  logic              misalign_o;

  int errors = 0;
  int checks = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  logic spur_ack = 1'b0;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] acc_q[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [7:0]        wb_q[$];

  mem_lsu #(.ADDR_W(ADDR_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .ld_i(ld_i), .st_i(st_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .sdata_i(sdata_i),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // RAM model: acks after wait_cfg wait cycles, writes land with the ack.
  always @(negedge clk) begin
    ram_ack_i = 1'b0;
    if (ram_req_o && !rst) begin
      if (wcnt >= wait_cfg) begin
        ram_ack_i   = 1'b1;
        wcnt        = 0;
        ram_rdata_i = mem[ram_addr_o];
        if (ram_we_o) begin
          mem[ram_addr_o] = ram_wdata_o;
          wa_q.push_back(ram_addr_o);
          wb_q.push_back(ram_wdata_o);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt      = 0;
      ram_ack_i = spur_ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_gap;
    tick;
    ld_i = 1'b0;
    st_i = 1'b0;
    tick;
  endtask

  // Samples each cycle from arrival until the DONE cycle (stall drops).
  task automatic run_txn(input int budget, output int n_xfer, output logic arr_ok,
                         output int unstable, output logic done);
    logic              prev_req;
    logic              prev_ack;
    logic [ADDR_W-1:0] pa;
    logic              pw;
    logic [7:0]        pd;
    n_xfer   = 0;
    arr_ok   = 1'b0;
    unstable = 0;
    done     = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    pa = '0; pw = 1'b0; pd = 8'd0;
    acc_q.delete();
    for (int c = 0; c < budget && !done; c++) begin
      samp;
      if (c == 0) begin
        arr_ok = stall_o && !ram_req_o && !wreg_o;
      end else if (!stall_o) begin
        done = 1'b1;
      end
      if (stall_o && ram_req_o) n_xfer++;
      if (ram_req_o) begin
        if (prev_req && !prev_ack &&
            (ram_addr_o !== pa || ram_we_o !== pw || ram_wdata_o !== pd)) unstable++;
        if (ram_ack_i) acc_q.push_back(ram_addr_o);
      end
      prev_req = ram_req_o;
      prev_ack = ram_ack_i;
      pa = ram_addr_o; pw = ram_we_o; pd = ram_wdata_o;
    end
  endtask

  int   n_xfer;
  int   unstable;
  logic arr_ok;
  logic done;
  logic seen_req;

  initial begin
    rst = 1'b1; ld_i = 1'b0; st_i = 1'b0; funct3_i = 3'b000; addr_i = '0;
    sdata_i = 32'd0; wd_i = '0; wreg_i = 1'b0; wdata_i = 32'd0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    mem[17'h100] = 8'h11; mem[17'h101] = 8'h22; mem[17'h102] = 8'h33; mem[17'h103] = 8'h44;
    mem[17'h010] = 8'h80;
    mem[17'h300] = 8'h34; mem[17'h301] = 8'hF2;

    // Reset with a live request on the inputs
    tick;
    ld_i = 1'b1; funct3_i = 3'b010; addr_i = 17'h100; wd_i = 5'd3; wreg_i = 1'b1;
    wdata_i = 32'h1234_5678;
    samp;
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(ram_req_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);

    // Pass-through, with a spurious ack that must be ignored
    tick;
    rst = 1'b0; ld_i = 1'b0; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF; spur_ack = 1'b1;
    samp;
    chk("pass_wd", 32'(wd_o), 32'd5);
    chk("pass_wreg", 32'(wreg_o), 32'd1);
    chk("pass_wdata", wdata_o, 32'hDEAD_BEEF);
    chk("pass_stall", 32'(stall_o), 32'd0);
    chk("pass_req", 32'(ram_req_o), 32'd0);
    tick;
    wreg_i = 1'b0; wdata_i = 32'h0BAD_F00D;
    samp;
    chk("pass2_wdata", wdata_o, 32'h0BAD_F00D);
    chk("pass2_wreg", 32'(wreg_o), 32'd0);
    chk("pass2_req", 32'(ram_req_o), 32'd0);
    tick;
    spur_ack = 1'b0;

    // LW 0x100, single-cycle acks
    ld_i = 1'b1; funct3_i = 3'b010; addr_i = 17'h100; wd_i = 5'd7; wreg_i = 1'b1;
    wdata_i = 32'h0000_CAFE;
    run_txn(40, n_xfer, arr_ok, unstable, done);
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_arrival_stall", 32'(arr_ok), 32'd1);
    chk("lw_xfer_stall_cycles", n_xfer, 32'd4);
    chk("lw_nbytes", acc_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("lw_addr", 32'((i < acc_q.size()) ? acc_q[i] : '1), 32'h100 + i);
    chk("lw_wdata", wdata_o, 32'h4433_2211);
    chk("lw_wreg", 32'(wreg_o), 32'd1);
    chk("lw_wd", 32'(wd_o), 32'd7);
    chk("lw_done_stall", 32'(stall_o), 32'd0);
    idle_gap;

    // LB then LBU of 0x80 at 0x10
    ld_i = 1'b1; funct3_i = 3'b000; addr_i = 17'h010; wd_i = 5'd8; wreg_i = 1'b1;
    run_txn(20, n_xfer, arr_ok, unstable, done);
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_xfer_cycles", n_xfer, 32'd1);
    chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
    idle_gap;
    ld_i = 1'b1; funct3_i = 3'b100;
    run_txn(20, n_xfer, arr_ok, unstable, done);
    chk("lbu_done", 32'(done), 32'd1);
    chk("lbu_wdata", wdata_o, 32'h0000_0080);
    idle_gap;

    // LH at 0x300 sign-extends 0xF234
    ld_i = 1'b1; funct3_i = 3'b001; addr_i = 17'h300;
    run_txn(20, n_xfer, arr_ok, unstable, done);
    chk("lh_done", 32'(done), 32'd1);
    chk("lh_xfer_cycles", n_xfer, 32'd2);
    chk("lh_wdata", wdata_o, 32'hFFFF_F234);
    idle_gap;

    // SH at the top of the address space wraps to 0
    wa_q.delete(); wb_q.delete();
    st_i = 1'b1; funct3_i = 3'b001; addr_i = 17'h1FFFF; sdata_i = 32'h0000_ABCD;
    wd_i = 5'd9; wreg_i = 1'b1;
    run_txn(20, n_xfer, arr_ok, unstable, done);
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_nwrites", wa_q.size(), 32'd2);
    chk("sh_a0", 32'((wa_q.size() > 0) ? wa_q[0] : '1), 32'h1FFFF);
    chk("sh_d0", 32'((wb_q.size() > 0) ? wb_q[0] : '1), 32'hCD);
    chk("sh_a1", 32'((wa_q.size() > 1) ? wa_q[1] : '1), 32'h00000);
    chk("sh_d1", 32'((wb_q.size() > 1) ? wb_q[1] : '1), 32'hAB);
    chk("sh_wreg", 32'(wreg_o), 32'd0);
    chk("sh_wdata", wdata_o, 32'd0);
    idle_gap;

    // LW with three wait states per byte
    wait_cfg = 3;
    ld_i = 1'b1; funct3_i = 3'b010; addr_i = 17'h100; wd_i = 5'd10; wreg_i = 1'b1;
    run_txn(60, n_xfer, arr_ok, unstable, done);
    chk("lwd_done", 32'(done), 32'd1);
    chk("lwd_xfer_stall_cycles", n_xfer, 32'd16);
    chk("lwd_unstable", unstable, 32'd0);
    chk("lwd_wdata", wdata_o, 32'h4433_2211);
    chk("lwd_wreg", 32'(wreg_o), 32'd1);
    wait_cfg = 0;
    idle_gap;

    // Illegal size code and simultaneous ld/st
    ld_i = 1'b1; funct3_i = 3'b011; wreg_i = 1'b1;
    samp;
    chk("ill_req", 32'(ram_req_o), 32'd0);
    chk("ill_wreg", 32'(wreg_o), 32'd0);
    chk("ill_stall", 32'(stall_o), 32'd0);
    tick;
    st_i = 1'b1; funct3_i = 3'b010;
    samp;
    chk("ldst_req", 32'(ram_req_o), 32'd0);
    chk("ldst_wreg", 32'(wreg_o), 32'd0);
    chk("ldst_stall", 32'(stall_o), 32'd0);
    idle_gap;

    // SW interrupted by reset after the second ack
    wa_q.delete(); wb_q.delete();
    st_i = 1'b1; funct3_i = 3'b010; addr_i = 17'h200; sdata_i = 32'h5566_7788;
    samp; tick;
    samp; tick;
    samp; tick;
    rst = 1'b1;
    samp;
    chk("swrst_req", 32'(ram_req_o), 32'd0);
    chk("swrst_stall", 32'(stall_o), 32'd0);
    tick;
    rst = 1'b0; st_i = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp;
      seen_req = seen_req | ram_req_o;
      tick;
    end
    chk("swrst_no_req_after", 32'(seen_req), 32'd0);
    chk("swrst_nwrites", wa_q.size(), 32'd2);
    chk("swrst_a1", 32'((wa_q.size() > 1) ? wa_q[1] : '1), 32'h201);
    chk("swrst_d1", 32'((wb_q.size() > 1) ? wb_q[1] : '1), 32'h77);
    chk("swrst_mem202", 32'(mem[17'h202]), 32'd0);

    // LH at odd address 0x101
    ld_i = 1'b1; funct3_i = 3'b001; addr_i = 17'h101; wd_i = 5'd11; wreg_i = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
    samp;
    chk("mis_flag", 32'(misalign_o), 32'd1);
    chk("mis_req", 32'(ram_req_o), 32'd0);
    chk("mis_wreg", 32'(wreg_o), 32'd0);
    chk("mis_stall", 32'(stall_o), 32'd0);
    tick;
    ld_i = 1'b0;
    samp;
    chk("mis_flag_clear", 32'(misalign_o), 32'd0);
    chk("mis_req_after", 32'(ram_req_o), 32'd0);
`else
    run_txn(20, n_xfer, arr_ok, unstable, done);
    chk("lhu_odd_done", 32'(done), 32'd1);
    chk("lh_odd_nbytes", acc_q.size(), 32'd2);
    chk("lh_odd_a0", 32'((acc_q.size() > 0) ? acc_q[0] : '1), 32'h101);
    chk("lh_odd_wdata", wdata_o, 32'h0000_3322);
    chk("lh_odd_misalign", 32'(misalign_o), 32'd0);
`endif
    idle_gap;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 17, meaning the RAM byte-address width.
REQ-002 The module SHALL have parameter RA_W, default 5, meaning the register-file address width.
REQ-003 The module SHALL have port clk, input, 1 bit: the clock.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have ports wd_i (input, RA_W), wreg_i (input, 1) and wdata_i (input, 32): destination register, write enable and ALU result from EX/MEM.
REQ-006 The module SHALL have ports ld_i (input, 1), st_i (input, 1) and funct3_i (input, 3): load request, store request and RV32I size/sign code.
REQ-007 The module SHALL have ports addr_i (input, ADDR_W) and sdata_i (input, 32): effective address and store data.
REQ-008 The module SHALL have ports ram_req_o (output, 1), ram_we_o (output, 1), ram_addr_o (output, ADDR_W) and ram_wdata_o (output, 8): byte-wide RAM request.
REQ-009 The module SHALL have ports ram_rdata_i (input, 8) and ram_ack_i (input, 1): byte-wide RAM response.
REQ-010 The module SHALL have ports wd_o (output, RA_W), wreg_o (output, 1), wdata_o (output, 32), stall_o (output, 1) and misalign_o (output, 1): writeback outputs, pipeline stall request and misalignment flag.

Function
REQ-011 With ld_i=st_i=0, outputs SHALL pass wd_i/wreg_i/wdata_i through combinationally, stall_o=0, ram_req_o=0.
REQ-012 Size SHALL be byte for funct3 x00, half for x01, word for 010; unsigned loads (LBU 100, LHU 101) SHALL zero-extend, LB/LH SHALL sign-extend.
REQ-013 An illegal code (011, 110, 111) or ld_i=st_i=1 SHALL cause no RAM access, wreg_o=0, stall_o=0.
REQ-014 FSM states SHALL be IDLE, XFER, DONE; IDLE->XFER on a legal ld_i or st_i, XFER->DONE on the ack of the last byte, DONE->IDLE unconditionally.
REQ-015 stall_o SHALL be 1 combinationally from the arrival cycle in IDLE through the final-ack cycle in XFER, and 0 in DONE.
REQ-016 In XFER, byte k (k=0..N-1, N=1/2/4) SHALL be accessed at ram_addr_o=addr_i+k modulo 2^ADDR_W, little-endian; for stores, ram_wdata_o=sdata_i[8k+7:8k] and ram_we_o=st_i.
REQ-017 ram_req_o SHALL be held with stable addr/we/wdata until ram_ack_i; k SHALL advance on ack; the next byte SHALL be requested the following cycle; ram_ack_i with ram_req_o=0 SHALL be ignored.
REQ-018 On ack of a load byte, ram_rdata_i SHALL be captured into assembly byte k.
REQ-019 In DONE, a load SHALL drive wd_o=wd_i, wreg_o=wreg_i and wdata_o=extended assembled value; a store SHALL drive wreg_o=0 and wdata_o=0.
REQ-020 Minimum load latency SHALL be N+1 cycles with single-cycle acks, and each ack wait state SHALL add one cycle.

Reset
REQ-021 On rst, the FSM SHALL enter IDLE, clear k and the assembly register, and drive ram_req_o=0 and misalign_o=0, including during XFER (a partial store is abandoned).
REQ-022 During reset, wd_o=0, wreg_o=0, wdata_o=0 and stall_o=0.

Configuration
REQ-023 With MEM_MISALIGN_CHECK_EN defined, a half access with addr_i[0]=1 or a word access with addr_i[1:0]!=0 SHALL make no RAM access, pulse misalign_o=1 for one cycle with wreg_o=0 and stall_o=0, and remain in IDLE.
REQ-024 Without MEM_MISALIGN_CHECK_EN, any alignment SHALL be accessed byte-serially per REQ-016, and misalign_o SHALL be constant 0.

Verification
REQ-025 LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44, single-cycle ack -> addr 0x100..0x103, stall 4 cycles, DONE wdata_o=0x44332211, wreg_o=1.
REQ-026 LB at 0x10 of byte 0x80, then LBU of the same byte -> wdata_o=0xFFFFFF80, then wdata_o=0x00000080.
REQ-027 SH at 0x1FFFF with sdata=0xABCD, ADDR_W=17, macro off -> writes 0xCD@0x1FFFF then 0xAB@0x00000, wreg_o=0.
REQ-028 LW with ack delayed 3 cycles per byte -> request held stable, stall 16 cycles, correct data in DONE.
REQ-029 rst asserted after the second ack of an SW -> next cycle IDLE, ram_req_o=0, stall_o=0, no further writes.
REQ-030 Macro on, LH at 0x101 -> misalign_o=1 for one cycle, ram_req_o never asserted, wreg_o=0.
